wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources.
- Port 0 is the in-order pipeline MEM/WB stage; port 1 is a multi-cycle unit (divider or late load return).
- Fixed priority goes to port 0, with a starvation guard for port 1.
- Output is one registered write per cycle, feeding the regfile we/waddr/wdata.

---
 rtl/wb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Two-source writeback arbiter for the single regfile write port: port 0 (pipeline) has priority,
// port 1 (multi-cycle unit) is forced through after MAX_WAIT refusals. Define WB_ARB_TRACE_EN for sim trace/checks.
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              p0_stall
);

    typedef enum logic {P0_PRI, P1_PRI} state_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              p0_xfer, p1_xfer;

    // Grants are combinational so a requester learns acceptance in the same cycle.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                P1_PRI: begin
                    p1_ready = p1_valid;
                    p0_ready = p0_valid && !p1_valid;
                end
                default: begin
                    p0_ready = p0_valid;
                    p1_ready = p1_valid && !p0_valid;
                end
            endcase
        end
        p0_xfer  = p0_valid && p0_ready;
        p1_xfer  = p1_valid && p1_ready;
        p0_stall = p0_valid && !p0_ready && !rst;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            P0_PRI:  if (p1_valid && !p1_ready && wait_cnt_q == WAIT_LIM) state_d = P1_PRI;
            default: state_d = P0_PRI;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (!p1_valid || p1_xfer)
            wait_cnt_d = 4'd0;
        else if (wait_cnt_q != WAIT_LIM)
            wait_cnt_d = wait_cnt_q + 4'd1;

        // x0 transfers are accepted but never reach the regfile; address/data then hold.
        rf_we_d    = (p0_xfer && p0_addr != '0) || (p1_xfer && p1_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (p0_xfer && p0_addr != '0) begin
            rf_waddr_d = p0_addr;
            rf_wdata_d = p0_data;
        end else if (p1_xfer && p1_addr != '0) begin
            rf_waddr_d = p1_addr;
            rf_wdata_d = p1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= P0_PRI;
            wait_cnt_q <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_TRACE_EN
    logic src_q, src_d;
    logic p0_pend_q, p0_pend_d;
    logic p1_pend_q, p1_pend_d;

    always_comb begin
        src_d     = p1_xfer;
        p0_pend_d = p0_valid && !p0_ready && !rst;
        p1_pend_d = p1_valid && !p1_ready && !rst;
    end

    always_ff @(posedge clk) begin
        src_q     <= src_d;
        p0_pend_q <= p0_pend_d;
        p1_pend_q <= p1_pend_d;
    end

    always @(posedge clk) begin
        if (!rst && rf_we_q)
            $display("wb %0d %h %h", src_q, rf_waddr_q, rf_wdata_q);
        if (!rst && p0_pend_q && !p0_valid)
            $display("wb_port_arbiter error: p0_valid dropped before transfer");
        if (!rst && p1_pend_q && !p1_valid)
            $display("wb_port_arbiter error: p1_valid dropped before transfer");
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a grant/refusal-count reference model.
module tb_wb_port_arbiter;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_valid, p1_valid;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_data, p1_data;
    logic              p0_ready, p1_ready, rf_we, p0_stall;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .p0_stall(p0_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: p1 is forced once it has been refused MAX_WAIT consecutive cycles.
    int                refused  = 0;
    bit                exp_we   = 1'b0;
    bit                exp_ad   = 1'b1;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    bit                g0 = 1'b0, g1 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit forced;
        #1;
        forced = p1_valid && refused >= MAX_WAIT;
        g1 = !rst && p1_valid && (forced || !p0_valid);
        g0 = !rst && p0_valid && !forced;
        chk("p0_ready", p0_ready, g0);
        chk("p1_ready", p1_ready, g1);
        chk("p0_stall", p0_stall, p0_valid && !g0 && !rst);
        chk("rf_we", rf_we, exp_we);
        if (exp_we || exp_ad) begin
            chk("rf_waddr", rf_waddr, exp_addr);
            chk("rf_wdata", rf_wdata, exp_data);
        end
        if (rst) begin
            refused  = 0;
            exp_we   = 1'b0;
            exp_ad   = 1'b1;
            exp_addr = '0;
            exp_data = '0;
        end else begin
            refused = (g1 || !p1_valid) ? 0 : refused + 1;
            exp_ad  = 1'b0;
            exp_we  = (g0 && p0_addr != 0) || (g1 && p1_addr != 0);
            if (exp_we) begin
                exp_addr = g0 ? p0_addr : p1_addr;
                exp_data = g0 ? p0_data : p1_data;
            end
        end
    endtask

    task automatic cyc();
        tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_data = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        // single p0 write
        p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hDEADBEEF;
        tick();
        chk("p0_single_ready", p0_ready, 1);
        @(negedge clk);
        p0_valid = 1'b0;
        tick();
        chk("p0_single_we", rf_we, 1);
        chk("p0_single_addr", rf_waddr, 5);
        chk("p0_single_data", rf_wdata, 32'hDEADBEEF);
        @(negedge clk);

        // contention then starvation guard
        p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'h11;
        for (int k = 0; k < 6; k++) begin
            if (g0 || !p0_valid) begin
                p0_valid = 1'b1; p0_addr = 5'(k + 1); p0_data = $urandom;
            end
            if (k == 5) p1_valid = 1'b0;
            tick();
            if (k == 0) chk("cont_p0_wins", p0_ready, 1);
            if (k < 4) chk("starv_refused", p1_ready, 0);
            if (k == 4) begin
                chk("starv_p1_forced", p1_ready, 1);
                chk("starv_p0_stall", p0_stall, 1);
            end
            if (k == 5) begin
                chk("starv_waddr", rf_waddr, 7);
                chk("starv_wdata", rf_wdata, 32'h11);
                chk("starv_p0_again", p0_ready, 1);
            end
            @(negedge clk);
        end
        p0_valid = 1'b0;
        cyc();

        // x0 write is accepted but dropped
        p1_valid = 1'b1; p1_addr = '0; p1_data = 32'hFFFFFFFF;
        tick();
        chk("x0_ready", p1_ready, 1);
        @(negedge clk);
        p1_valid = 1'b0;
        tick();
        chk("x0_no_we", rf_we, 0);
        @(negedge clk);

        // reset during the third refused p1 cycle
        p1_valid = 1'b1; p1_addr = 5'd9; p1_data = $urandom;
        for (int k = 0; k < 3; k++) begin
            if (g0 || !p0_valid) begin
                p0_valid = 1'b1; p0_addr = 5'($urandom_range(1, 31)); p0_data = $urandom;
            end
            rst = (k == 2);
            tick();
            if (k == 2) chk("rst_p1_not_ready", p1_ready, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        tick();
        chk("rst_no_we", rf_we, 0);
        chk("rst_p0_wins", p0_ready, 1);
        chk("rst_p1_refused", p1_ready, 0);
        @(negedge clk);

        // random traffic, protocol-respecting holds, occasional reset
        for (int i = 0; i < 4000; i++) begin
            int pct0, pct1;
            pct0 = (i / 500) % 2 == 0 ? 90 : 40;
            pct1 = (i / 250) % 3 == 0 ? 80 : 30;
            rst = ($urandom_range(0, 199) == 0);
            if (!(p0_valid && !g0)) begin
                p0_valid = ($urandom_range(0, 99) < pct0);
                p0_addr  = 5'($urandom);
                p0_data  = $urandom;
            end
            if (!(p1_valid && !g1)) begin
                p1_valid = ($urandom_range(0, 99) < pct1);
                p1_addr  = 5'($urandom);
                p1_data  = $urandom;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
